seg_scan_decoder: RTL and testbench

//  Receive-side counterpart of the 7-segment display driver. Monitors the multiplexed seg/dig bus.

---
 rtl/seg_scan_decoder.sv | 185 ++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive side of the multiplexed 7-segment bus.
// Watches {seg,dig}, waits for each scan step to be stable for STABLE_CYC samples,
// then decodes the segment pattern back to a 4-bit code stored per digit slot.
// Optional feature macro: SEG_SCAN_HEX_EN (also decode hex letters A..F as codes 10..15).
module seg_scan_decoder #(
    parameter int unsigned NUM_DIG    = 8,
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned IDX_W      = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             seg,
    input  logic [NUM_DIG-1:0]     dig,
    output logic [4*NUM_DIG-1:0]   val,
    output logic [NUM_DIG-1:0]     blank,
    output logic [NUM_DIG-1:0]     dp_out,
    output logic                   upd,
    output logic [IDX_W-1:0]       upd_idx,
    output logic                   err,
    output logic [1:0]             err_code
);

    localparam int unsigned SMP_W = 8 + NUM_DIG;
    localparam int unsigned CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {StWait, StHold} state_e;

    // Returns {hit, code} for a seg[7:1] pattern; dp is not part of the match.
    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        logic [4:0] r;
        r = 5'b0_0000;
        case (p)
            7'b1111110: r = 5'b1_0000;
            7'b0110000: r = 5'b1_0001;
            7'b1101101: r = 5'b1_0010;
            7'b1111001: r = 5'b1_0011;
            7'b0110011: r = 5'b1_0100;
            7'b1011011: r = 5'b1_0101;
            7'b1011111: r = 5'b1_0110;
            7'b1110000: r = 5'b1_0111;
            7'b1111111: r = 5'b1_1000;
            7'b1111011: r = 5'b1_1001;
`ifdef SEG_SCAN_HEX_EN
            7'b1110111: r = 5'b1_1010;
            7'b0011111: r = 5'b1_1011;
            7'b1001110: r = 5'b1_1100;
            7'b0111101: r = 5'b1_1101;
            7'b1001111: r = 5'b1_1110;
            7'b1000111: r = 5'b1_1111;
`endif
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SMP_W-1:0]     smp_q;
    logic [4*NUM_DIG-1:0] val_q, val_d;
    logic [NUM_DIG-1:0]   blank_q, blank_d;
    logic [NUM_DIG-1:0]   dp_q, dp_d;
    logic                 upd_q, err_q;
    logic [IDX_W-1:0]     upd_idx_q, upd_idx_d;
    logic [1:0]           err_code_q, err_code_d;

    logic                 same;
    logic                 step;
    logic [7:0]           seg_s;
    logic [NUM_DIG-1:0]   dig_s;
    int unsigned          n_zero;
    logic [IDX_W-1:0]     hit_idx;
    logic [4:0]           dec;
    logic                 wr_en;
    logic                 err_en;
    logic [3:0]           wr_code;
    logic                 wr_blank;

    assign same  = ({seg, dig} == smp_q);
    assign seg_s = smp_q[SMP_W-1 -: 8];
    assign dig_s = smp_q[NUM_DIG-1:0];

    // Stability counter and WAIT/HOLD sequencing; step fires once per stable period.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step    = 1'b0;
        if (!same) begin
            state_d = StWait;
            cnt_d   = '0;
        end else begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            if (state_q == StWait && cnt_q == CNT_LAST) begin
                step    = 1'b1;
                state_d = StHold;
            end
        end
    end

    // Classify the stable step: which digit is selected and what the segments mean.
    always_comb begin
        n_zero     = 0;
        hit_idx    = '0;
        dec        = decode_seg(seg_s[7:1]);
        wr_en      = 1'b0;
        err_en     = 1'b0;
        err_code_d = 2'b00;
        wr_code    = 4'h0;
        wr_blank   = 1'b0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (!dig_s[i]) begin
                n_zero  = n_zero + 1;
                hit_idx = IDX_W'(i);
            end
        end
        if (step && n_zero > 1) begin
            err_en     = 1'b1;
            err_code_d = 2'b10;
        end else if (step && n_zero == 1) begin
            if (seg_s[7:1] == 7'b0000000) begin
                wr_en    = 1'b1;
                wr_blank = 1'b1;
            end else if (dec[4]) begin
                wr_en   = 1'b1;
                wr_code = dec[3:0];
            end else begin
                err_en     = 1'b1;
                err_code_d = 2'b01;
            end
        end
    end

    // Register-file next state: only the selected slot changes on a write.
    always_comb begin
        val_d     = val_q;
        blank_d   = blank_q;
        dp_d      = dp_q;
        upd_idx_d = upd_idx_q;
        if (wr_en) upd_idx_d = hit_idx;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (wr_en && hit_idx == IDX_W'(i)) begin
                val_d[4*i +: 4] = wr_code;
                blank_d[i]      = wr_blank;
                dp_d[i]         = seg_s[0];
            end
        end
    end

    // All state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StWait;
            cnt_q      <= '0;
            smp_q      <= '0;
            val_q      <= '0;
            blank_q    <= '1;
            dp_q       <= '0;
            upd_q      <= 1'b0;
            upd_idx_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            smp_q      <= {seg, dig};
            val_q      <= val_d;
            blank_q    <= blank_d;
            dp_q       <= dp_d;
            upd_q      <= wr_en;
            upd_idx_q  <= upd_idx_d;
            err_q      <= err_en;
            err_code_q <= err_code_d;
        end
    end

    assign val      = val_q;
    assign blank    = blank_q;
    assign dp_out   = dp_q;
    assign upd      = upd_q;
    assign upd_idx  = upd_idx_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (default parameters, STABLE_CYC = 4).
// Honours SEG_SCAN_HEX_EN for the hex-letter case.
module tb_seg_scan_decoder;

    localparam int unsigned NUM_DIG    = 8;
    localparam int unsigned STABLE_CYC = 4;
    localparam int unsigned IDX_W      = 3;

    logic                 clk;
    logic                 rst;
    logic [7:0]           seg;
    logic [NUM_DIG-1:0]   dig;
    logic [4*NUM_DIG-1:0] val;
    logic [NUM_DIG-1:0]   blank;
    logic [NUM_DIG-1:0]   dp_out;
    logic                 upd;
    logic [IDX_W-1:0]     upd_idx;
    logic                 err;
    logic [1:0]           err_code;

    int n_checks;
    int n_errors;
    int n_upd, first_upd, n_err, first_err;
    int last_idx, last_code;

    seg_scan_decoder #(
        .NUM_DIG    (NUM_DIG),
        .STABLE_CYC (STABLE_CYC),
        .IDX_W      (IDX_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .seg      (seg),
        .dig      (dig),
        .val      (val),
        .blank    (blank),
        .dp_out   (dp_out),
        .upd      (upd),
        .upd_idx  (upd_idx),
        .err      (err),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one step from a negedge, hold it ncyc cycles, record pulses (cycle 1 = first edge).
    task automatic apply(input logic [7:0] s, input logic [7:0] d, input int ncyc);
        seg = s;
        dig = d;
        n_upd = 0; first_upd = 0; n_err = 0; first_err = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (upd) begin
                n_upd++;
                if (first_upd == 0) first_upd = c;
                last_idx = int'(upd_idx);
            end
            if (err) begin
                n_err++;
                if (first_err == 0) first_err = c;
                last_code = int'(err_code);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        last_idx = 0;
        last_code = 0;
        rst = 1'b0;
        seg = 8'h00;
        dig = 8'hFF;

        // 1: reset with toggling inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seg = 8'h60 ^ 8'(i * 37);
            dig = (i % 2 == 0) ? 8'hFE : 8'hFB;
        end
        chk("rst_val", val, 32'h0);
        chk("rst_blank", 32'(blank), 32'hFF);
        chk("rst_dp", 32'(dp_out), 32'h0);
        chk("rst_upd", 32'(upd), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst = 1'b1;
        apply(8'h00, 8'hFF, STABLE_CYC + 2);
        chk("post_rst_pulses", 32'(n_upd + n_err), 32'h0);
        chk("post_rst_blank", 32'(blank), 32'hFF);

        // 2: digit 2 on slot 2, latency STABLE_CYC+1
        apply(8'b11011010, 8'b11111011, 10);
        chk("t2_upd_count", 32'(n_upd), 32'd1);
        chk("t2_latency", 32'(first_upd), 32'd5);
        chk("t2_err_count", 32'(n_err), 32'd0);
        chk("t2_idx", 32'(last_idx), 32'd2);
        chk("t2_val", 32'(val[11:8]), 32'h2);
        chk("t2_blank", 32'(blank[2]), 32'h0);
        chk("t2_dp", 32'(dp_out[2]), 32'h0);

        // 3: short glitch, then a stable "1" on slot 0
        apply(8'b11110010, 8'b11111110, 2);
        chk("t3_glitch_pulses", 32'(n_upd + n_err), 32'd0);
        apply(8'b01100000, 8'b11111110, 10);
        chk("t3_upd_count", 32'(n_upd), 32'd1);
        chk("t3_idx", 32'(last_idx), 32'd0);
        chk("t3_val", val, 32'h0000_0201);
        chk("t3_blank", 32'(blank), 32'hFA);

        // 4: two digits selected at once
        apply(8'b01100000, 8'b11110011, 6);
        chk("t4_err_count", 32'(n_err), 32'd1);
        chk("t4_err_code", 32'(last_code), 32'd2);
        chk("t4_upd_count", 32'(n_upd), 32'd0);
        chk("t4_val", val, 32'h0000_0201);
        chk("t4_blank", 32'(blank), 32'hFA);

        // 5: hex letter A on slot 5
        apply(8'b11101110, 8'b11011111, 8);
`ifdef SEG_SCAN_HEX_EN
        chk("t5_upd_count", 32'(n_upd), 32'd1);
        chk("t5_err_count", 32'(n_err), 32'd0);
        chk("t5_idx", 32'(last_idx), 32'd5);
        chk("t5_val", 32'(val[23:20]), 32'hA);
        chk("t5_blank", 32'(blank[5]), 32'h0);
`else
        chk("t5_upd_count", 32'(n_upd), 32'd0);
        chk("t5_err_count", 32'(n_err), 32'd1);
        chk("t5_err_code", 32'(last_code), 32'd1);
        chk("t5_val", 32'(val[23:20]), 32'h0);
        chk("t5_blank", 32'(blank[5]), 32'h1);
`endif

        // 6: blank with dp on slot 0, then reset while in HOLD
        apply(8'b00000001, 8'b11111110, 8);
        chk("t6_upd_count", 32'(n_upd), 32'd1);
        chk("t6_blank0", 32'(blank[0]), 32'h1);
        chk("t6_dp0", 32'(dp_out[0]), 32'h1);
        chk("t6_val0", 32'(val[3:0]), 32'h0);
        rst = 1'b0;
        #1;
        chk("t6_rst_val", val, 32'h0);
        chk("t6_rst_blank", 32'(blank), 32'hFF);
        chk("t6_rst_dp", 32'(dp_out), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        apply(8'b00000001, 8'b11111110, 3);
        chk("t6_no_stale", 32'(n_upd + n_err), 32'd0);
        apply(8'b00000001, 8'b11111110, 4);
        chk("t6_recapture_at", 32'(first_upd), 32'd2);
        chk("t6_recapture_dp", 32'(dp_out), 32'h01);

        // 7: digit 9 with dp on the top slot
        apply(8'b11110111, 8'b01111111, 8);
        chk("t7_upd_count", 32'(n_upd), 32'd1);
        chk("t7_idx", 32'(last_idx), 32'd7);
        chk("t7_val", 32'(val[31:28]), 32'h9);
        chk("t7_dp", 32'(dp_out), 32'h81);
        chk("t7_blank", 32'(blank), 32'h7F);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
